// File: rtl/expand_bias_relu.sv
// expand_bias_relu: adds a per-channel sign-magnitude bias to each accumulator word.
// The sum is saturated to 16 bits and can be clamped at zero (ReLU).
// It is a two-stage pipeline with a valid/ready handshake on both sides.
// Channel and pixel counters follow the stream so that the last word of a frame is tagged.
module expand_bias_relu #(
  parameter int CHANNELS   = 128,
  parameter int NUM_PIXELS = 3136,
  parameter int ACC_W      = 32,
  parameter int BIAS_SHIFT = 0,
  parameter int RELU_EN    = 1,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [15:0]      bias_mem [CHANNELS],
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CW-1:0]    out_chan,
  output logic             out_last,
  output logic             frame_done
);

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] SAT_MIN = -(ACC_W+1)'(32768);

  logic [CW-1:0]           chan_reg, chan_next;
  logic [PW-1:0]           pix_reg, pix_next;
  logic                    adv, accept, last_now;
  logic signed [ACC_W:0]   bias_tbl [CHANNELS];
  logic signed [ACC_W:0]   sum_next;
  logic [15:0]             result_next;

  logic                    s1_valid_reg;
  logic signed [ACC_W:0]   s1_sum_reg;
  logic [CW-1:0]           s1_chan_reg;
  logic                    s1_last_reg;
  logic                    out_valid_reg, out_last_reg, frame_done_reg;
  logic [15:0]             out_data_reg;
  logic [CW-1:0]           out_chan_reg;

  // The whole pipeline moves together whenever the output slot is free or being drained.
  assign adv      = !out_valid_reg || out_ready;
  assign in_ready = adv && !clear;
  assign accept   = in_valid && in_ready;
  assign last_now = (chan_reg == CW'(CHANNELS-1)) && (pix_reg == PW'(NUM_PIXELS-1));

  // Each table entry is decoded to a signed, shift-aligned bias.
  // Negative zero (16'h8000) decodes to 0 because -0 == 0.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_bias
      logic signed [ACC_W:0] mag;
      assign mag          = (ACC_W+1)'(bias_mem[gi][14:0]) << BIAS_SHIFT;
      assign bias_tbl[gi] = bias_mem[gi][15] ? -mag : mag;
    end
  endgenerate

  // S1 adder: sign-extend one bit so that the sum can never overflow.
  always_comb begin
    sum_next = {in_data[ACC_W-1], in_data} + bias_tbl[chan_reg];
  end

  // S2 saturation to int16, then an optional clamp of negative values to zero.
  always_comb begin
    result_next = s1_sum_reg[15:0];
    if (s1_sum_reg > SAT_MAX)      result_next = 16'h7FFF;
    else if (s1_sum_reg < SAT_MIN) result_next = 16'h8000;
    if ((RELU_EN != 0) && result_next[15]) result_next = 16'h0000;
  end

  // Channel/pixel position of the next word to be accepted.
  always_comb begin
    chan_next = chan_reg;
    pix_next  = pix_reg;
    if (accept) begin
      if (chan_reg == CW'(CHANNELS-1)) begin
        chan_next = '0;
        pix_next  = (pix_reg == PW'(NUM_PIXELS-1)) ? '0 : pix_reg + 1'b1;
      end else begin
        chan_next = chan_reg + 1'b1;
      end
    end
  end

  // Counter state, reset by rst_n or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_reg <= '0;
      pix_reg  <= '0;
    end else if (clear) begin
      chan_reg <= '0;
      pix_reg  <= '0;
    end else begin
      chan_reg <= chan_next;
      pix_reg  <= pix_next;
    end
  end

  // Two pipeline stages. Both hold during an output stall.
  // Payload registers load only with valid data, so bubbles do not disturb the held output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_sum_reg    <= '0;
      s1_chan_reg   <= '0;
      s1_last_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (clear) begin
      s1_valid_reg  <= 1'b0;
      s1_sum_reg    <= '0;
      s1_chan_reg   <= '0;
      s1_last_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (adv) begin
      s1_valid_reg  <= accept;
      if (accept) begin
        s1_sum_reg  <= sum_next;
        s1_chan_reg <= chan_reg;
        s1_last_reg <= last_now;
      end
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg <= result_next;
        out_chan_reg <= s1_chan_reg;
        out_last_reg <= s1_last_reg;
      end
    end
  end

  // One-cycle pulse after the final word of a frame leaves the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      frame_done_reg <= 1'b0;
    else if (clear)  frame_done_reg <= 1'b0;
    else             frame_done_reg <= out_valid_reg && out_ready && out_last_reg;
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_chan   = out_chan_reg;
  assign out_last   = out_last_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_expand_bias_relu.sv
// Directed bench for expand_bias_relu.
// Two instances share the same stimulus: one with ReLU on, one with ReLU off.
// Both use a 2-pixel frame.
module tb_expand_bias_relu;
  localparam int CH = 128;
  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic [15:0] bias_tab [CH];

  logic        in_ready_a, out_valid_a, out_last_a, frame_done_a;
  logic [15:0] out_data_a;
  logic [6:0]  out_chan_a;
  logic        in_ready_b, out_valid_b, out_last_b, frame_done_b;
  logic [15:0] out_data_b;
  logic [6:0]  out_chan_b;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  expand_bias_relu #(.CHANNELS(CH), .NUM_PIXELS(NP), .ACC_W(32), .BIAS_SHIFT(0), .RELU_EN(1)) u_relu (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bias_mem(bias_tab),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_chan(out_chan_a), .out_last(out_last_a), .frame_done(frame_done_a)
  );

  expand_bias_relu #(.CHANNELS(CH), .NUM_PIXELS(NP), .ACC_W(32), .BIAS_SHIFT(0), .RELU_EN(0)) u_lin (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bias_mem(bias_tab),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_chan(out_chan_b), .out_last(out_last_b), .frame_done(frame_done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result: integer add, clip to int16, optional clamp at zero.
  function automatic logic [15:0] model(input int d, input logic [15:0] b, input bit relu);
    int s;
    s = d + (b[15] ? -int'(b[14:0]) : int'(b[14:0]));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return 16'(s);
  endfunction

  function automatic int dat(input int k);
    return ((k * 173) % 4000) - 2000;
  endfunction

  // Offer one word. Return at the sampling point two edges after the accept.
  task automatic send_one(input logic [31:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1 chk("in_ready_on_send", 32'(in_ready_a), 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  int          d_vec [5] = '{100, -500, 40000, -40000, 1234};
  logic [15:0] ea    [5] = '{16'd54, 16'h0000, 16'h7FFF, 16'h0000, 16'd1234};
  logic [15:0] eb    [5] = '{16'd54, 16'hFE3E, 16'h7FFF, 16'h8000, 16'd1234};

  initial begin
    int  sent, recv, cyc;
    bit  hs, prev_fd;

    bias_tab[0] = 16'h802E;
    bias_tab[1] = 16'h0032;
    bias_tab[2] = 16'h000A;
    bias_tab[3] = 16'h0000;
    bias_tab[4] = 16'h8000;
    for (int i = 5; i < CH; i++)
      bias_tab[i] = (i % 2 == 1) ? (16'h8000 | 16'(i * 97)) : 16'(i * 97);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid_a), 0);
    chk("rst_out_data", 32'(out_data_a), 0);
    chk("rst_out_chan", 32'(out_chan_a), 0);
    chk("rst_out_last", 32'(out_last_a), 0);
    chk("rst_frame_done", 32'(frame_done_a), 0);
    chk("rst_out_valid_b", 32'(out_valid_b), 0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready_a), 1);

    // Directed single words on channels 0..4
    for (int i = 0; i < 5; i++) begin
      send_one(32'(d_vec[i]));
      $display("directed ch%0d in=%0d relu=%0h lin=%0h", i, d_vec[i], out_data_a, out_data_b);
      chk("dir_valid", 32'(out_valid_a), 1);
      chk("dir_chan", 32'(out_chan_a), i);
      chk("dir_data_relu", 32'(out_data_a), 32'(ea[i]));
      chk("dir_data_lin", 32'(out_data_b), 32'(eb[i]));
      chk("dir_last", 32'(out_last_a), 0);
    end

    // clear wins over an offered word
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'd7;
    #1 chk("clear_in_ready", 32'(in_ready_a), 0);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_out_valid", 32'(out_valid_a), 0);
    chk("clear_out_chan", 32'(out_chan_a), 0);

    // Full frame (2 pixels x 128 channels) with random stalls on both sides
    sent = 0; recv = 0; cyc = 0; prev_fd = 1'b0;
    while (recv < 2 * CH && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      chk("frame_done_cycle", 32'(frame_done_a), 32'(prev_fd));
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 2 * CH && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = 32'(dat(sent));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready_a) sent++;
      hs = out_valid_a && out_ready;
      prev_fd = hs && out_last_a;
      if (hs) begin
        $display("stream word %0d chan=%0d relu=%0h lin=%0h last=%0b", recv, out_chan_a, out_data_a, out_data_b, out_last_a);
        chk("stream_chan", 32'(out_chan_a), recv % CH);
        chk("stream_chan_b", 32'(out_chan_b), recv % CH);
        chk("stream_data_relu", 32'(out_data_a), 32'(model(dat(recv), bias_tab[recv % CH], 1'b1)));
        chk("stream_data_lin", 32'(out_data_b), 32'(model(dat(recv), bias_tab[recv % CH], 1'b0)));
        chk("stream_last", 32'(out_last_a), (recv == 2 * CH - 1) ? 1 : 0);
        recv++;
      end
    end
    chk("stream_count", 32'(recv), 2 * CH);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("frame_done_pulse", 32'(frame_done_a), 1);
    chk("frame_done_pulse_b", 32'(frame_done_b), 1);
    @(negedge clk);
    chk("frame_done_drop", 32'(frame_done_a), 0);

    // Counters wrapped: the next word is channel 0 of a new frame
    send_one(32'd100);
    chk("wrap_chan", 32'(out_chan_a), 0);
    chk("wrap_data", 32'(out_data_a), 54);
    chk("wrap_last", 32'(out_last_b), 0);

    // Async reset mid-pixel with two words in flight
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("inflight_valid", 32'(out_valid_a), 1);
    chk("inflight_chan", 32'(out_chan_a), 35);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid_a), 0);
    chk("async_rst_chan", 32'(out_chan_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_one(32'd100);
    chk("post_rst_valid", 32'(out_valid_a), 1);
    chk("post_rst_chan", 32'(out_chan_a), 0);
    chk("post_rst_data", 32'(out_data_a), 54);
    chk("post_rst_ready_b", 32'(in_ready_b), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
